io_input_conditioner: RTL and testbench

- Conditions the raw board inputs (16 slide switches, 5 push buttons) before they reach the CPU IO read path.
- Per bit: 2-flop synchronisation, then debounce.
- Keeps a sticky per-button press-event register. The CPU clears it by reading the event address on the IO bus.
- Sits directly upstream of the top-level IO read mux, which registers sw_stable, btn_stable and btn_event into io_read_value.

---
 rtl/io_input_conditioner.sv | 95 +++++++++
 tb/tb_io_input_conditioner.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/io_input_conditioner.sv
// Board input conditioner: 2-flop sync and per-bit debounce for 16 switches and
// 5 buttons, plus a sticky button-press event register cleared by an IO read.

module io_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
)(
  input  logic clk,
  input  logic rst,
  input  logic i_sync,
  input  logic i_stable,
  output logic o_stable_nxt
);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_diff;
  logic                 w_done;

  assign w_diff       = (i_sync != i_stable);
  assign w_done       = w_diff && (r_cnt == LAST);
  assign o_stable_nxt = w_done ? i_sync : i_stable;

  // Any sample matching the stable level restarts the count.
  always_ff @(posedge clk) begin
    if (rst)                  r_cnt <= '0;
    else if (!w_diff || w_done) r_cnt <= '0;
    else                      r_cnt <= r_cnt + 1'b1;
  end
endmodule

module io_input_conditioner #(
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter int          CNT_WIDTH       = 20,
  parameter logic [31:0] EVT_ADDR        = 32'h3
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw_raw,
  input  logic [4:0]  btn_raw,
  input  logic [31:0] io_address,
  input  logic        io_read_en,
  output logic [15:0] sw_stable,
  output logic [4:0]  btn_stable,
  output logic [4:0]  btn_event
);
  localparam int NB = 21;

  logic [NB-1:0] r_s1, r_s2, r_stable;
  logic [NB-1:0] w_stable_nxt;
  logic [4:0]    r_evt;
  logic [4:0]    w_rise;
  logic          w_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= {btn_raw, sw_raw};
      r_s2 <= r_s1;
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_db
    io_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_db (
      .clk          (clk),
      .rst          (rst),
      .i_sync       (r_s2[g]),
      .i_stable     (r_stable[g]),
      .o_stable_nxt (w_stable_nxt[g])
    );
  end

  assign w_rise = w_stable_nxt[NB-1:16] & ~r_stable[NB-1:16];
  assign w_clr  = io_read_en && (io_address == EVT_ADDR);

  // A press landing on the clearing edge survives: set wins over clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable <= '0;
      r_evt    <= '0;
    end else begin
      r_stable <= w_stable_nxt;
      r_evt    <= (w_clr ? 5'b0 : r_evt) | w_rise;
    end
  end

  assign sw_stable  = r_stable[15:0];
  assign btn_stable = r_stable[NB-1:16];
  assign btn_event  = r_evt;
endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: vector table, directed corner sequences and a
// random run compared against a sample-history reference model.

module tb_io_input_conditioner;
  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw_raw = '0;
  logic [4:0]  btn_raw = '0;
  logic [31:0] io_address = '0;
  logic        io_read_en = 1'b0;
  logic [15:0] sw_stable;
  logic [4:0]  btn_stable;
  logic [4:0]  btn_event;

  int checks = 0;
  int errors = 0;

  io_input_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_WIDTH(3), .EVT_ADDR(32'h3)) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .btn_raw(btn_raw),
    .io_address(io_address), .io_read_en(io_read_en),
    .sw_stable(sw_stable), .btn_stable(btn_stable), .btn_event(btn_event)
  );

  always #5 clk = ~clk;

  // Reference: a level flips once the last DC synchronised samples since reset
  // all disagree with it; sync is a plain two-sample delay of the raw inputs.
  logic [20:0] m_s1 = '0, m_s2 = '0, m_stab = '0;
  logic [4:0]  m_evt = '0;
  logic [20:0] hist[$];

  task automatic model_step();
    logic [20:0] nxt;
    logic        all;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_evt = '0;
      hist.delete();
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > DC) void'(hist.pop_front());
      nxt = m_stab;
      for (int b = 0; b < 21; b++) begin
        all = (hist.size() == DC);
        for (int j = 0; j < hist.size(); j++)
          if (hist[j][b] == m_stab[b]) all = 1'b0;
        if (all) nxt[b] = ~m_stab[b];
      end
      m_evt  = ((io_read_en && io_address == 32'h3) ? 5'b0 : m_evt) | (nxt[20:16] & ~m_stab[20:16]);
      m_stab = nxt;
      m_s2   = m_s1;
      m_s1   = {btn_raw, sw_raw};
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model", {sw_stable, btn_stable, btn_event}, {m_stab[15:0], m_stab[20:16], m_evt});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic        r;
    logic [15:0] sw;
    logic [4:0]  btn;
    logic        rd;
    logic [31:0] addr;
    int          n;
    logic [15:0] esw;
    logic [4:0]  ebtn;
    logic [4:0]  eevt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b1, 16'hFFFF, 5'h1F, 1'b0, 32'd0, 3, 16'h0000, 5'h00, 5'h00};
    tbl[1]  = '{1'b0, 16'hFFFF, 5'h1F, 1'b0, 32'd0, 5, 16'h0000, 5'h00, 5'h00};
    tbl[2]  = '{1'b0, 16'hFFFF, 5'h1F, 1'b0, 32'd0, 1, 16'hFFFF, 5'h1F, 5'h1F};
    tbl[3]  = '{1'b0, 16'hFFFF, 5'h1F, 1'b1, 32'd3, 1, 16'hFFFF, 5'h1F, 5'h00};
    tbl[4]  = '{1'b0, 16'h0000, 5'h00, 1'b0, 32'd0, 8, 16'h0000, 5'h00, 5'h00};
    tbl[5]  = '{1'b0, 16'h0000, 5'h04, 1'b0, 32'd0, 6, 16'h0000, 5'h04, 5'h04};
    tbl[6]  = '{1'b0, 16'h0000, 5'h04, 1'b1, 32'd2, 1, 16'h0000, 5'h04, 5'h04};
    tbl[7]  = '{1'b0, 16'h0000, 5'h04, 1'b1, 32'd3, 1, 16'h0000, 5'h04, 5'h00};
    tbl[8]  = '{1'b0, 16'h0000, 5'h14, 1'b0, 32'd0, 6, 16'h0000, 5'h14, 5'h10};
    tbl[9]  = '{1'b0, 16'h0000, 5'h04, 1'b0, 32'd0, 6, 16'h0000, 5'h04, 5'h10};
    tbl[10] = '{1'b0, 16'h0000, 5'h00, 1'b1, 32'd3, 1, 16'h0000, 5'h04, 5'h00};
    tbl[11] = '{1'b0, 16'h0000, 5'h00, 1'b0, 32'd0, 6, 16'h0000, 5'h00, 5'h00};

    for (int v = 0; v < 12; v++) begin
      rst = tbl[v].r; sw_raw = tbl[v].sw; btn_raw = tbl[v].btn;
      io_read_en = tbl[v].rd; io_address = tbl[v].addr;
      ticks(tbl[v].n);
      chk($sformatf("vec%0d_sw", v),  32'(sw_stable),  32'(tbl[v].esw));
      chk($sformatf("vec%0d_btn", v), 32'(btn_stable), 32'(tbl[v].ebtn));
      chk($sformatf("vec%0d_evt", v), 32'(btn_event),  32'(tbl[v].eevt));
    end
    io_read_en = 1'b0; io_address = '0;

    // Switch latency: visible exactly on the 6th edge.
    sw_raw = 16'h0001;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("lat_e%0d", k), 32'(sw_stable), (k == 6) ? 32'h1 : 32'h0);
    end

    // Short pulse on sw[1] is rejected.
    sw_raw = 16'h0003; ticks(3);
    sw_raw = 16'h0001;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("glitch", 32'(sw_stable), 32'h1);
    end

    // Bouncy press on btn[2].
    btn_raw = 5'h04; tick(); btn_raw = 5'h00; tick();
    btn_raw = 5'h04; tick(); btn_raw = 5'h00; tick();
    btn_raw = 5'h04;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("bounce_e%0d", k), 32'(btn_stable), (k == 6) ? 32'h4 : 32'h0);
    end
    chk("bounce_evt", 32'(btn_event), 32'h4);

    // Set wins over clear on the same edge.
    btn_raw = 5'h0C; ticks(6);
    chk("pre_collide_evt", 32'(btn_event), 32'h0C);
    btn_raw = 5'h0D; ticks(5);
    io_read_en = 1'b1; io_address = 32'h3;
    tick();
    io_read_en = 1'b0; io_address = '0;
    chk("collide_btn", 32'(btn_stable), 32'h0D);
    chk("collide_evt", 32'(btn_event), 32'h01);

    // Reset in the middle of a debounce, then full latency again.
    sw_raw = 16'h0003; ticks(4);
    chk("midrst_pre", 32'(sw_stable), 32'h1);
    rst = 1'b1; ticks(2);
    chk("midrst_in", {11'd0, sw_stable, btn_stable, btn_event}, 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("midrst_sw_e%0d", k), 32'(sw_stable), (k == 6) ? 32'h3 : 32'h0);
      chk($sformatf("midrst_btn_e%0d", k), 32'(btn_stable), (k == 6) ? 32'h0D : 32'h0);
    end
    chk("midrst_evt", 32'(btn_event), 32'h0D);

    // Random run: sparse bit flips so both debounce and glitches occur.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        int b;
        b = $urandom_range(0, 20);
        if (b < 16) sw_raw[b] = ~sw_raw[b];
        else        btn_raw[b-16] = ~btn_raw[b-16];
      end
      io_read_en = ($urandom_range(0, 3) == 0);
      io_address = ($urandom_range(0, 1) == 0) ? 32'h3 : 32'($urandom_range(0, 7));
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
